// File: rtl/edac_scrubber.sv
// Background scrubber: walks [FIRST_ADDR, LAST_ADDR], reads each 32-bit word holding two
// CRC-protected 16-bit codewords, and writes back corrected (or poisoned) words.
module edac_scrubber #(
  parameter int          ADDR_W     = 8,
  parameter int          FIRST_ADDR = 0,
  parameter int          LAST_ADDR  = 255,
  parameter int          RD_LATENCY = 1,
  parameter int          CNT_W      = 16,
  parameter int          POISON     = 1,
  parameter logic [31:0] ERROR_CODE = 32'hFFFFFFFF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WRITE, NEXT, DONE} state_t;

  // Single-bit syndromes for bit positions 7..0 of a codeword's low byte.
  localparam logic [31:0] SYN_TAB = 32'h7FB98421;

  state_t      state, state_nx;
  logic [2:0]  wait_cnt;
  logic        wait_last;
  logic        at_last;
  logic [31:0] rdata_q;

  logic [1:0][15:0] fixed;
  logic [1:0]       corr;
  logic [1:0]       bad;
  logic             any_bad, any_corr;
  logic [1:0]       n_corr;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    sat_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign wait_last = (wait_cnt == 3'(RD_LATENCY - 1));
  assign at_last   = (mem_addr == ADDR_W'(LAST_ADDR));
  assign state_dbg = state;

  // Syndrome check and single-bit correction of both halves of the captured word.
  always_comb begin
    logic [15:0] cw;
    logic [3:0]  syn;
    fixed = rdata_q;
    corr  = '0;
    bad   = '0;
    for (int h = 0; h < 2; h++) begin
      cw  = rdata_q[16*h +: 16];
      syn = cw[3:0] ^ ({4{cw[4]}} & 4'h9) ^ ({4{cw[5]}} & 4'hB)
                    ^ ({4{cw[6]}} & 4'hF) ^ ({4{cw[7]}} & 4'h7);
      bad[h] = (cw[15:8] != 8'h00);
      if (!bad[h] && syn != 4'h0) begin
        bad[h] = 1'b1;
        for (int b = 0; b < 8; b++) begin
          if (syn == SYN_TAB[4*b +: 4]) begin
            fixed[h][b] = ~cw[b];
            corr[h]     = 1'b1;
            bad[h]      = 1'b0;
          end
        end
      end
    end
  end

  assign any_bad  = |bad;
  assign any_corr = |corr;
  assign n_corr   = {1'b0, corr[0]} + {1'b0, corr[1]};

  always_ff @(posedge CLK) begin
    if (reset)   state <= IDLE;
    else if (en) state <= state_nx;
  end

  // Strobes are gated by en and reset so a frozen or aborted pass never touches memory.
  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = READ;
      READ: begin
        mem_rd   = en & ~reset;
        state_nx = WAIT;
      end
      WAIT:  if (wait_last) state_nx = CHECK;
      CHECK: begin
        if (any_bad)       state_nx = (POISON != 0) ? WRITE : NEXT;
        else if (any_corr) state_nx = WRITE;
        else               state_nx = NEXT;
      end
      WRITE: begin
        mem_wr   = en & ~reset;
        state_nx = NEXT;
      end
      NEXT:  state_nx = at_last ? DONE : READ;
      DONE: begin
        done     = en & ~reset;
        state_nx = start ? READ : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      err_flag   <= 1'b0;
      err_addr   <= '0;
      wait_cnt   <= '0;
      rdata_q    <= '0;
    end else if (en) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mem_addr   <= ADDR_W'(FIRST_ADDR);
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            err_flag   <= 1'b0;
            err_addr   <= '0;
            busy       <= 1'b1;
          end
        end
        READ: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_last) rdata_q <= mem_rdata;
        end
        CHECK: begin
          // A word with any uncorrectable half counts once; its corrected halves do not count.
          if (any_bad) begin
            uncorr_cnt <= sat_add(uncorr_cnt, 2'd1);
            mem_wdata  <= ERROR_CODE;
            if (!err_flag) begin
              err_flag <= 1'b1;
              err_addr <= mem_addr;
            end
          end else if (any_corr) begin
            corr_cnt  <= sat_add(corr_cnt, n_corr);
            mem_wdata <= fixed;
          end
        end
        NEXT: begin
          if (at_last) busy <= 1'b0;
          else         mem_addr <= mem_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edac_scrubber.sv
// Bench for edac_scrubber: three parameterisations driven one at a time against a memory
// model; expected writes and end-of-pass results are queued and checked by a monitor.
module tb_edac_scrubber;

  localparam int WW = 42;  // {inst, addr, data}
  localparam int RW = 59;  // {inst, reads, corr, uncorr, flag, err_addr, cycles}

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic        start [3];
  logic        en    [3];
  logic        busy_v[3], done_v[3], rd_v[3], wr_v[3], flag_v[3];
  logic [7:0]  addr_v[3], eaddr_v[3];
  logic [31:0] rdata_v[3], wdata_v[3];
  logic [2:0]  st_v[3];
  logic [15:0] corr_a, uncorr_a, corr_c, uncorr_c;
  logic [1:0]  corr_b, uncorr_b;
  logic [15:0] corr_v[3], uncorr_v[3];

  always_comb begin
    corr_v[0]   = corr_a;
    corr_v[1]   = {14'b0, corr_b};
    corr_v[2]   = corr_c;
    uncorr_v[0] = uncorr_a;
    uncorr_v[1] = {14'b0, uncorr_b};
    uncorr_v[2] = uncorr_c;
  end

  // A: 4 words, latency 1, poison on.
  edac_scrubber #(.ADDR_W(8), .FIRST_ADDR(0), .LAST_ADDR(3), .RD_LATENCY(1), .CNT_W(16), .POISON(1))
  u_a (.CLK(CLK), .reset(reset), .en(en[0]), .start(start[0]), .busy(busy_v[0]), .done(done_v[0]),
       .mem_addr(addr_v[0]), .mem_rd(rd_v[0]), .mem_rdata(rdata_v[0]), .mem_wr(wr_v[0]),
       .mem_wdata(wdata_v[0]), .corr_cnt(corr_a), .uncorr_cnt(uncorr_a), .err_flag(flag_v[0]),
       .err_addr(eaddr_v[0]), .state_dbg(st_v[0]));

  // B: 6 words at 2..7, latency 3, 2-bit counters, poison off.
  edac_scrubber #(.ADDR_W(8), .FIRST_ADDR(2), .LAST_ADDR(7), .RD_LATENCY(3), .CNT_W(2), .POISON(0))
  u_b (.CLK(CLK), .reset(reset), .en(en[1]), .start(start[1]), .busy(busy_v[1]), .done(done_v[1]),
       .mem_addr(addr_v[1]), .mem_rd(rd_v[1]), .mem_rdata(rdata_v[1]), .mem_wr(wr_v[1]),
       .mem_wdata(wdata_v[1]), .corr_cnt(corr_b), .uncorr_cnt(uncorr_b), .err_flag(flag_v[1]),
       .err_addr(eaddr_v[1]), .state_dbg(st_v[1]));

  // C: single word at 5, latency 2.
  edac_scrubber #(.ADDR_W(8), .FIRST_ADDR(5), .LAST_ADDR(5), .RD_LATENCY(2), .CNT_W(16), .POISON(1))
  u_c (.CLK(CLK), .reset(reset), .en(en[2]), .start(start[2]), .busy(busy_v[2]), .done(done_v[2]),
       .mem_addr(addr_v[2]), .mem_rd(rd_v[2]), .mem_rdata(rdata_v[2]), .mem_wr(wr_v[2]),
       .mem_wdata(wdata_v[2]), .corr_cnt(corr_c), .uncorr_cnt(uncorr_c), .err_flag(flag_v[2]),
       .err_addr(eaddr_v[2]), .state_dbg(st_v[2]));

  // Memory model: pipe[i][0] holds the last read, later stages add latency.
  logic [31:0] mem  [3][256];
  logic [31:0] pipe [3][3];
  logic        load_en = 1'b0;
  logic [1:0]  load_id = '0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_v[i]) mem[i][addr_v[i]] <= wdata_v[i];
      if (rd_v[i]) pipe[i][0] <= mem[i][addr_v[i]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
    if (load_en) mem[load_id][load_addr] <= load_data;
  end

  always_comb begin
    rdata_v[0] = pipe[0][0];
    rdata_v[1] = pipe[1][2];
    rdata_v[2] = pipe[2][1];
  end

  // Scoreboard
  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  int reads[3] = '{0, 0, 0};
  int t0[3]    = '{0, 0, 0};
  logic [WW-1:0] exp_q[$];
  logic [RW-1:0] res_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    logic [WW-1:0] we, wa;
    logic [RW-1:0] re, ra;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        reads[i] = 0;
      end else begin
        if (rd_v[i] || wr_v[i]) begin
          compared++;
          if (rd_v[i] && wr_v[i]) begin
            failed++;
            $display("FAIL strobe_excl inst%0d: rd=1 wr=1, required at most one", i);
          end
        end
        if (rd_v[i]) begin
          if (reads[i] == 0) t0[i] = cyc;
          reads[i]++;
        end
        if (wr_v[i]) begin
          compared++;
          wa = {2'(i), addr_v[i], wdata_v[i]};
          if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL write inst%0d: got addr %h data %h, required no write", i, addr_v[i], wdata_v[i]);
          end else begin
            we = exp_q.pop_front();
            if (wa !== we) begin
              failed++;
              $display("FAIL write inst%0d: got %h, required %h", i, wa, we);
            end
          end
        end
        if (done_v[i]) begin
          compared++;
          ra = {2'(i), 8'(reads[i]), corr_v[i], uncorr_v[i], flag_v[i], eaddr_v[i], 8'(cyc - t0[i])};
          if (res_q.size() == 0) begin
            failed++;
            $display("FAIL pass_result inst%0d: got %h, required no done", i, ra);
          end else begin
            re = res_q.pop_front();
            if (ra !== re) begin
              failed++;
              $display("FAIL pass_result inst%0d: got %h, required %h", i, ra, re);
            end
          end
          reads[i] = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int id, input int a, input logic [31:0] d);
    exp_q.push_back({2'(id), 8'(a), d});
  endtask

  task automatic exp_res(input int id, input int rd, input int c, input int u,
                         input int f, input int ea, input int cy);
    res_q.push_back({2'(id), 8'(rd), 16'(c), 16'(u), 1'(f), 8'(ea), 8'(cy)});
  endtask

  task automatic ld(input int id, input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_id   = 2'(id);
    load_addr = 8'(a);
    load_data = d;
    @(posedge CLK); #1;
    load_en   = 1'b0;
  endtask

  task automatic fill(input int id, input int f, input int l, input logic [31:0] d);
    for (int a = f; a <= l; a++) ld(id, a, d);
  endtask

  task automatic kick(input int id);
    start[id] = 1'b1;
    @(posedge CLK); #1;
    start[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!done_v[id] && n < 600);
    if (!done_v[id]) begin
      compared++;
      failed++;
      $display("FAIL done_timeout inst%0d: no done within %0d cycles, required done", id, n);
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_state(input int id, input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(posedge CLK); #1;
      ok = (st_v[id] == s);
    end
    if (!ok) begin
      compared++;
      failed++;
      $display("FAIL state_timeout inst%0d: state %0d never reached, required it", id, s);
    end
  endtask

  localparam logic [31:0] CLEAN = 32'h00320056;

  initial begin
    bit ok;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      en[i]    = 1'b1;
    end
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outputs inst%0d", i),
            {busy_v[i], done_v[i], rd_v[i], wr_v[i], addr_v[i], wdata_v[i], corr_v[i][3:0],
             uncorr_v[i][3:0], flag_v[i], eaddr_v[i], st_v[i]}, 64'd0);
    @(posedge CLK); #1;

    // Clean pass: no writes, done 16 cycles after the first read.
    fill(0, 0, 3, CLEAN);
    exp_res(0, 4, 0, 0, 0, 0, 16);
    kick(0); wait_done(0);

    // Single-bit error in the low half.
    fill(0, 0, 3, CLEAN); ld(0, 2, 32'h00320057);
    exp_wr(0, 2, CLEAN); exp_res(0, 4, 1, 0, 0, 0, 17);
    kick(0); wait_done(0);

    // Both halves carry a single-bit error.
    fill(0, 0, 3, CLEAN); ld(0, 1, 32'h00B20046);
    exp_wr(0, 1, CLEAN); exp_res(0, 4, 2, 0, 0, 0, 17);
    kick(0); wait_done(0);

    // Uncorrectable words are poisoned; the first failing address is recorded.
    fill(0, 0, 3, CLEAN); ld(0, 0, 32'h01320056); ld(0, 3, 32'h00320055);
    exp_wr(0, 0, 32'hFFFFFFFF); exp_wr(0, 3, 32'hFFFFFFFF); exp_res(0, 4, 0, 2, 1, 0, 18);
    kick(0); wait_done(0);
    repeat (5) @(negedge CLK);
    check("hold_after_done", {corr_v[0], uncorr_v[0], flag_v[0], eaddr_v[0], addr_v[0], busy_v[0], done_v[0]},
          {16'd0, 16'd2, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0});
    @(posedge CLK); #1;

    // start held high during the pass must not restart it.
    fill(0, 0, 3, CLEAN);
    exp_res(0, 4, 0, 0, 0, 0, 16);
    start[0] = 1'b1;
    repeat (10) @(posedge CLK);
    #1 start[0] = 1'b0;
    wait_done(0);

    // en low for 5 cycles in the first WAIT stretches the pass by 5 cycles.
    fill(0, 0, 3, CLEAN); ld(0, 2, 32'h00320057);
    exp_wr(0, 2, CLEAN); exp_res(0, 4, 1, 0, 0, 0, 22);
    start[0] = 1'b1;
    wait_state(0, 3'd2, ok);
    start[0] = 1'b0;
    en[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check($sformatf("freeze%0d", k), {rd_v[0], wr_v[0], st_v[0]}, {1'b0, 1'b0, 3'd2});
      @(posedge CLK);
    end
    #1 en[0] = 1'b1;
    wait_done(0);

    // Reset during WRITE: the write is suppressed and the counters clear.
    fill(0, 0, 3, CLEAN); ld(0, 1, 32'h00320057);
    start[0] = 1'b1;
    wait_state(0, 3'd4, ok);
    start[0] = 1'b0;
    reset = 1'b1;
    @(negedge CLK);
    check("reset_write_gated", {31'd0, wr_v[0]}, 64'd0);
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    check("reset_midpass", {busy_v[0], wr_v[0], rd_v[0], corr_v[0], uncorr_v[0], st_v[0]}, 64'd0);
    @(posedge CLK); #1;

    // Saturation: five corrected words on a 2-bit counter.
    fill(1, 2, 7, CLEAN);
    for (int a = 2; a <= 6; a++) ld(1, a, 32'h00320057);
    for (int a = 2; a <= 6; a++) exp_wr(1, a, CLEAN);
    exp_res(1, 6, 3, 0, 0, 0, 41);
    kick(1); wait_done(1);

    // No poisoning: uncorrectable words (including one with a correctable half) are not written.
    fill(1, 2, 7, CLEAN);
    ld(1, 3, 32'h00320055); ld(1, 4, 32'h00550057); ld(1, 5, 32'h01320056); ld(1, 6, 32'h00B20046);
    exp_wr(1, 6, CLEAN); exp_res(1, 6, 2, 3, 1, 3, 37);
    kick(1); wait_done(1);

    // Single-word range, latency 2.
    ld(2, 5, 32'h00B20046);
    exp_wr(2, 5, CLEAN); exp_res(2, 1, 2, 0, 0, 0, 6);
    kick(2); wait_done(2);

    repeat (4) @(posedge CLK);
    check("write_queue_empty", 64'(exp_q.size()), 64'd0);
    check("result_queue_empty", 64'(res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
